fp8_seq_divider: RTL and testbench

- Iterative FP8 divider, the inverse operation of the team's combinational FP8 multiplier; same E4M3-style packing {sign, exp, mantissa} and bias.
- Computes a_in / b_in by restoring shift-subtract on the significands.
- Uses valid/ready handshakes on both sides, so it can sit behind the multiplier datapath or the pin mux.
- Handles one operation at a time.

---
 rtl/fp8_pkg.sv | 25 ++
 rtl/fp8_seq_divider_if.sv | 25 ++
 rtl/fp8_norm_round.sv | 77 +++++++
 rtl/fp8_seq_divider.sv | 130 +++++++++++++
 tb/tb_fp8_seq_divider.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fp8_pkg.sv
// Shared FP8 (E4M3-style, no denormals, no Inf/NaN) definitions for the divider and multiplier.
package fp8_pkg;

    localparam int EXP_BITS      = 4;
    localparam int MANTISSA_BITS = 3;
    localparam int BIAS          = (1 << (EXP_BITS - 1)) - 1;
    localparam int FP8_W         = 1 + EXP_BITS + MANTISSA_BITS;

    typedef struct packed {
        logic                     sign;
        logic [EXP_BITS-1:0]      exp;
        logic [MANTISSA_BITS-1:0] mant;
    } fp8_t;

    localparam logic [EXP_BITS-1:0]               FP8_MAX_EXP = '1;
    localparam logic [EXP_BITS+MANTISSA_BITS-1:0] FP8_MAX_MAG = '1;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } div_state_e;

endpackage

// File: rtl/fp8_seq_divider_if.sv
// Operand/result handshake bundle for fp8_seq_divider.
interface fp8_seq_divider_if #(
    parameter int W = fp8_pkg::FP8_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q_out;
    logic         div0;
    logic         ovf;
    logic         unf;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, q_out, div0, ovf, unf
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, q_out, div0, ovf, unf
    );
endinterface

// File: rtl/fp8_norm_round.sv
// Combinational normalize/round/range stage for FP8 quotients and products.
// Rounding mode: FP8_DIV_RNE_EN defined -> round-to-nearest-even, otherwise truncate.
module fp8_norm_round #(
    parameter int EXP_BITS      = fp8_pkg::EXP_BITS,
    parameter int MANTISSA_BITS = fp8_pkg::MANTISSA_BITS
) (
    input  logic                              [MANTISSA_BITS+2:0] q,
    input  logic                                                  rem_nz,
    input  logic signed                       [EXP_BITS+1:0]      e_raw,
    input  logic                                                  sign,
    input  logic                                                  div0_case,
    input  logic                                                  zero_case,
    output logic [EXP_BITS+MANTISSA_BITS:0]                       result,
    output logic                                                  div0,
    output logic                                                  ovf,
    output logic                                                  unf
);
    import fp8_pkg::*;

    localparam int QW = MANTISSA_BITS + 3;
    localparam int EW = EXP_BITS + 2;
    localparam int MW = EXP_BITS + MANTISSA_BITS;
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_BITS) - 1);
    localparam logic signed [EW-1:0] E_ONE = EW'(1);

    function automatic logic round_up(input logic guard, input logic sticky, input logic lsb);
`ifdef FP8_DIV_RNE_EN
        return guard & (sticky | lsb);
`else
        return 1'b0;
`endif
    endfunction

    logic [MANTISSA_BITS-1:0] mant;
    logic [MANTISSA_BITS-1:0] mant_r;
    logic                     guard;
    logic                     sticky;
    logic                     carry;
    logic signed [EW-1:0]     e_n;
    logic signed [EW-1:0]     e_r;

    always_comb begin
        // Quotient in [0.5, 2): a clear integer bit means one extra left shift.
        if (q[QW-1]) begin
            mant   = q[MANTISSA_BITS+1:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            e_n    = e_raw;
        end else begin
            mant   = q[MANTISSA_BITS:1];
            guard  = q[0];
            sticky = rem_nz;
            e_n    = e_raw - E_ONE;
        end

        {carry, mant_r} = {1'b0, mant} + (MANTISSA_BITS+1)'(round_up(guard, sticky, mant[0]));
        e_r = carry ? e_n + E_ONE : e_n;

        result = {sign, e_r[EXP_BITS-1:0], mant_r};
        div0   = 1'b0;
        ovf    = 1'b0;
        unf    = 1'b0;
        if (div0_case) begin
            result = {sign, {MW{1'b1}}};
            div0   = 1'b1;
        end else if (zero_case) begin
            result = {sign, {MW{1'b0}}};
        end else if (e_r > E_MAX) begin
            result = {sign, {MW{1'b1}}};
            ovf    = 1'b1;
        end else if (e_r < E_ONE) begin
            result = {sign, {MW{1'b0}}};
            unf    = 1'b1;
        end
    end

endmodule

// File: rtl/fp8_seq_divider.sv
// Iterative FP8 divider: restoring shift-subtract on significands, one op at a time.
// Optional FP8_DIV_RNE_EN selects round-to-nearest-even in fp8_norm_round (default truncate).
module fp8_seq_divider #(
    parameter int EXP_BITS      = fp8_pkg::EXP_BITS,
    parameter int MANTISSA_BITS = fp8_pkg::MANTISSA_BITS,
    parameter int BIAS          = (1 << (EXP_BITS - 1)) - 1
) (
    input logic              clk,
    input logic              rst,
    fp8_seq_divider_if.slave bus
);
    import fp8_pkg::*;

    localparam int W  = 1 + EXP_BITS + MANTISSA_BITS;
    localparam int QW = MANTISSA_BITS + 3;
    localparam int CW = $clog2(QW);
    localparam int RW = MANTISSA_BITS + 2;

    div_state_e                   state, state_n;
    logic [CW-1:0]                iter_cnt;
    logic [RW-1:0]                rem;
    logic [RW-2:0]                dvsr;
    logic [QW-1:0]                quo;
    logic                         sign;
    logic [EXP_BITS-1:0]          exp_a, exp_b;
    logic signed [EXP_BITS+1:0]   e_raw;
    logic [W-1:0]                 res, q_out_r;
    logic                         res_div0, res_ovf, res_unf;
    logic                         div0_r, ovf_r, unf_r;
    logic                         accept, last_iter;
    logic [EXP_BITS-1:0]          in_exp_a, in_exp_b;

    assign in_exp_a  = bus.a_in[W-2 -: EXP_BITS];
    assign in_exp_b  = bus.b_in[W-2 -: EXP_BITS];
    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_iter = (iter_cnt == CW'(QW - 1));

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.q_out     = q_out_r;
    assign bus.div0      = div0_r;
    assign bus.ovf       = ovf_r;
    assign bus.unf       = unf_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            iter_cnt <= '0;
        end else begin
            state <= state_n;
            if (accept)
                iter_cnt <= '0;
            else if (state == DIVIDE)
                iter_cnt <= iter_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (in_exp_a == '0 || in_exp_b == '0)
                        state_n = NORM;
                    else
                        state_n = DIVIDE;
                end
            end
            DIVIDE:  if (last_iter) state_n = NORM;
            NORM:    state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture and one quotient bit per DIVIDE cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign  <= bus.a_in[W-1] ^ bus.b_in[W-1];
            exp_a <= in_exp_a;
            exp_b <= in_exp_b;
            rem   <= {1'b0, 1'b1, bus.a_in[MANTISSA_BITS-1:0]};
            dvsr  <= {1'b1, bus.b_in[MANTISSA_BITS-1:0]};
            quo   <= '0;
        end else if (state == DIVIDE) begin
            if (rem >= {1'b0, dvsr}) begin
                rem <= (rem - {1'b0, dvsr}) << 1;
                quo <= {quo[QW-2:0], 1'b1};
            end else begin
                rem <= rem << 1;
                quo <= {quo[QW-2:0], 1'b0};
            end
        end
    end

    assign e_raw = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
                 + $signed((EXP_BITS + 2)'(BIAS));

    fp8_norm_round #(
        .EXP_BITS      (EXP_BITS),
        .MANTISSA_BITS (MANTISSA_BITS)
    ) u_norm_round (
        .q         (quo),
        .rem_nz    (|rem),
        .e_raw     (e_raw),
        .sign      (sign),
        .div0_case (exp_b == '0),
        .zero_case (exp_a == '0),
        .result    (res),
        .div0      (res_div0),
        .ovf       (res_ovf),
        .unf       (res_unf)
    );

    // Result register: loaded in NORM, held through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_out_r <= '0;
            div0_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (state == NORM) begin
            q_out_r <= res;
            div0_r  <= res_div0;
            ovf_r   <= res_ovf;
            unf_r   <= res_unf;
        end
    end

endmodule

// File: tb/tb_fp8_seq_divider.sv
// Directed scoreboard bench for fp8_seq_divider (E4M3 defaults).
module tb_fp8_seq_divider;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp8_seq_divider_if #(.W(8)) bus ();

    fp8_seq_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] q;
        logic [2:0] flg;
        int         lat;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] rne_q;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_DIV0 = 3'b100;
    localparam logic [2:0] F_OVF  = 3'b010;
    localparam logic [2:0] F_UNF  = 3'b001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one operation, track latency/busy, compare against the scoreboard,
    // optionally hold DONE for 'hold' cycles and present the next operands on release.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                          input logic [2:0] flg, input int lat, input int hold,
                          input bit chain, input logic [7:0] na, input logic [7:0] nb);
        exp_t e;
        exp_t got;
        int   edges;
        bit   busy_ok;
        e.q   = q;
        e.flg = flg;
        e.lat = lat;
        e.tag = $sformatf("%02h/%02h", a, b);
        sb.push_back(e);

        @(negedge clk);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        check({e.tag, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a_in     = 8'hFF;
        bus.b_in     = 8'h00;

        edges   = 0;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && edges < 20) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end

        got = sb.pop_front();
        check({got.tag, " latency"}, 32'(edges), 32'(got.lat));
        check({got.tag, " busy_in_ready_low"}, 32'(busy_ok), 32'd1);
        for (int i = 0; i <= hold; i++) begin
            check($sformatf("%s q_out c%0d", got.tag, i), 32'(bus.q_out), 32'(got.q));
            check($sformatf("%s flags c%0d", got.tag, i), 32'({bus.div0, bus.ovf, bus.unf}), 32'(got.flg));
            if (hold > 0) begin
                check($sformatf("%s done_in_ready c%0d", got.tag, i), 32'(bus.in_ready), 32'd0);
                check($sformatf("%s done_valid c%0d", got.tag, i), 32'(bus.out_valid), 32'd1);
            end
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end

        @(negedge clk);
        bus.out_ready = 1'b1;
        if (chain) begin
            bus.a_in     = na;
            bus.b_in     = nb;
            bus.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({got.tag, " released_valid"}, 32'(bus.out_valid), 32'd0);
        check({got.tag, " released_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_valid;
`ifdef FP8_DIV_RNE_EN
        rne_q = 8'hB3;
`else
        rne_q = 8'hB2;
`endif
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = 8'h00;
        bus.b_in      = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset q_out", 32'(bus.q_out), 32'd0);
        check("reset flags", 32'({bus.div0, bus.ovf, bus.unf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h40, 8'h38, 8'h40, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h44, 8'h40, 8'h3C, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'hB8, 8'h3C, rne_q, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h40, 8'h00, 8'h7F, F_DIV0, 1, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h80, 8'h40, 8'h80, F_NONE, 1, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h78, 8'h08, 8'h7F, F_OVF,  7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h08, 8'h78, 8'h00, F_UNF,  7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h38, 8'h3E, 8'h31, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h3F, 8'h38, 8'h3F, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h00, 8'h00, 8'h7F, F_DIV0, 1, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'hC0, 8'hC0, 8'h38, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h78, 8'h38, 8'h78, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h08, 8'h38, 8'h08, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);
        run_op(8'h08, 8'h40, 8'h00, F_UNF,  7, 0, 1'b0, 8'h00, 8'h00);

        // DONE held for 5 cycles; next operands presented during the release cycle.
        run_op(8'h40, 8'h38, 8'h40, F_NONE, 7, 5, 1'b1, 8'h44, 8'h40);
        run_op(8'h44, 8'h40, 8'h3C, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);

        // Abort in the third DIVIDE cycle.
        @(negedge clk);
        bus.a_in     = 8'h40;
        bus.b_in     = 8'h38;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort q_out", 32'(bus.q_out), 32'd0);
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort flags", 32'({bus.div0, bus.ovf, bus.unf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) saw_valid = 1'b1;
        end
        check("abort no_result", 32'(saw_valid), 32'd0);

        run_op(8'h38, 8'h3E, 8'h31, F_NONE, 7, 0, 1'b0, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
